// File: rtl/kp_midi_voice_ctrl.sv
// MIDI note-on front end for the Karplus-Strong voice: parses the byte stream and drives trig/velocity/delay_length.
// Define KP_MIDI_OMNI_EN to accept voice messages on every channel instead of MIDI_CH only.
module kp_midi_voice_ctrl #(
  parameter int MIDI_CH   = 0,
  parameter int TRIG_HOLD = 8,
  parameter int TRIG_GAP  = 8
) (
  input  logic       a_clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       trig,
  output logic [6:0] velocity,
  output logic [9:0] delay_length,
  output logic [6:0] note,
  output logic       note_active,
  output logic       ev_drop
);

  localparam int CMAX = (TRIG_HOLD > TRIG_GAP) ? TRIG_HOLD : TRIG_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, CALC, OUT, HOLD, GAP} state_t;

  // parser state
  logic       rs_vld, rs_on, in_data2;
  logic [6:0] d1_note;

  logic ch_ok, is_rt, is_voice, msg_done, msg_on, msg_off;

`ifdef KP_MIDI_OMNI_EN
  assign ch_ok = 1'b1;
`else
  assign ch_ok = (rx_data[3:0] == MIDI_CH[3:0]);
`endif

  assign is_rt    = (rx_data[7:3] == 5'b11111);
  assign is_voice = (rx_data[7:5] == 3'b100) && ch_ok;
  assign msg_done = rx_valid && !rx_data[7] && rs_vld && in_data2;
  assign msg_on   = msg_done && rs_on && (rx_data[6:0] != 7'd0);
  assign msg_off  = msg_done && !msg_on;

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      rs_vld   <= 1'b0;
      rs_on    <= 1'b0;
      in_data2 <= 1'b0;
      d1_note  <= '0;
    end else if (rx_valid) begin
      if (rx_data[7]) begin
        if (!is_rt) begin
          rs_vld   <= is_voice;
          rs_on    <= rx_data[4];
          in_data2 <= 1'b0;
        end
      end else if (rs_vld) begin
        if (!in_data2) d1_note <= rx_data[6:0];
        in_data2 <= !in_data2;
      end
    end
  end

  // strike engine and pending slot
  state_t         state;
  logic           pend_vld;
  logic [6:0]     pend_note, pend_vel, cur_note, cur_vel, w;
  logic [2:0]     oct;
  logic [CW-1:0]  cnt;
  logic [9:0]     period, dl_next;

  // one-octave period table, C3..B3 at 96 kHz
  always_comb begin
    period = 10'd734;
    case (w)
      7'd48: period = 10'd734;
      7'd49: period = 10'd693;
      7'd50: period = 10'd654;
      7'd51: period = 10'd617;
      7'd52: period = 10'd582;
      7'd53: period = 10'd550;
      7'd54: period = 10'd519;
      7'd55: period = 10'd490;
      7'd56: period = 10'd462;
      7'd57: period = 10'd436;
      7'd58: period = 10'd412;
      7'd59: period = 10'd389;
      default: period = 10'd734;
    endcase
    dl_next = (period >> oct) - 10'd1;
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      trig         <= 1'b1;
      velocity     <= '0;
      delay_length <= '0;
      note         <= '0;
      note_active  <= 1'b0;
      ev_drop      <= 1'b0;
      pend_vld     <= 1'b0;
      pend_note    <= '0;
      pend_vel     <= '0;
      cur_note     <= '0;
      cur_vel      <= '0;
      w            <= '0;
      oct          <= '0;
      cnt          <= '0;
    end else begin
      ev_drop <= 1'b0;
      if (msg_off && d1_note == note) note_active <= 1'b0;
      case (state)
        IDLE: if (pend_vld) begin
          pend_vld <= 1'b0;
          w        <= pend_note;
          cur_note <= pend_note;
          cur_vel  <= pend_vel;
          oct      <= '0;
          state    <= CALC;
        end
        // outputs register on the edge into OUT, so OUT is the first low cycle
        CALC: if (w < 7'd48) begin
          w <= w + 7'd12;
        end else if (w >= 7'd60) begin
          w   <= w - 7'd12;
          oct <= oct + 3'd1;
        end else begin
          velocity     <= cur_vel;
          note         <= cur_note;
          delay_length <= dl_next;
          note_active  <= 1'b1;
          trig         <= 1'b0;
          cnt          <= CW'(1);
          state        <= OUT;
        end
        OUT, HOLD: if (cnt == CW'(TRIG_HOLD)) begin
          trig  <= 1'b1;
          cnt   <= CW'(1);
          state <= GAP;
        end else begin
          cnt   <= cnt + CW'(1);
          state <= HOLD;
        end
        GAP: if (cnt == CW'(TRIG_GAP)) state <= IDLE;
             else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
      // a new note-on lands after any IDLE consume so it is never lost
      if (msg_on) begin
        pend_vld  <= 1'b1;
        pend_note <= d1_note;
        pend_vel  <= rx_data[6:0];
        ev_drop   <= pend_vld && (state != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_kp_midi_voice_ctrl.sv
// Directed bench for kp_midi_voice_ctrl: timing, tuning words, running status, drops and reset.
module tb_kp_midi_voice_ctrl;
  logic       a_clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       trig;
  logic [6:0] velocity;
  logic [9:0] delay_length;
  logic [6:0] note;
  logic       note_active;
  logic       ev_drop;

  int n_cmp = 0;
  int n_bad = 0;
  int drops = 0;
  logic trig_q = 1'b1;
  logic [6:0] s_note[$];
  logic [9:0] s_dl[$];

  kp_midi_voice_ctrl dut (
    .a_clk(a_clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .trig(trig), .velocity(velocity), .delay_length(delay_length), .note(note),
    .note_active(note_active), .ev_drop(ev_drop)
  );

  always #5 a_clk = ~a_clk;

  // strike log and drop counter, sampled away from the active edge
  always @(negedge a_clk) begin
    trig_q <= trig;
    if (trig_q === 1'b1 && trig === 1'b0) begin
      s_note.push_back(note);
      s_dl.push_back(delay_length);
    end
    if (ev_drop === 1'b1) drops <= drops + 1;
  end

  // called at a negedge; the byte occupies the following cycle
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge a_clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge a_clk);
  endtask

  // cycle index (velocity byte = cycle 0) of the first low trig and its low length
  task automatic wait_trig(output int first, output int len);
    first = -1;
    len   = 0;
    for (int c = 1; c <= 60; c++) begin
      if (first < 0 && trig === 1'b0) first = c;
      else if (first >= 0 && trig === 1'b1) begin
        len = c - first;
        break;
      end
      @(negedge a_clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    n_cmp++; if (trig !== 1'b1) begin n_bad++; $display("FAIL reset_trig got %b want 1", trig); end
    n_cmp++; if (velocity !== 7'd0) begin n_bad++; $display("FAIL reset_vel got %0d want 0", velocity); end
    n_cmp++; if (delay_length !== 10'd0) begin n_bad++; $display("FAIL reset_dl got %0d want 0", delay_length); end
    n_cmp++; if (note !== 7'd0) begin n_bad++; $display("FAIL reset_note got %0d want 0", note); end
    n_cmp++; if (note_active !== 1'b0) begin n_bad++; $display("FAIL reset_active got %b want 0", note_active); end
    n_cmp++; if (ev_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop got %b want 0", ev_drop); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_note_on;
    int f, l;
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    wait_trig(f, l);
    n_cmp++; if (f !== 4) begin n_bad++; $display("FAIL on_first_low got %0d want 4", f); end
    n_cmp++; if (l !== 8) begin n_bad++; $display("FAIL on_low_len got %0d want 8", l); end
    n_cmp++; if (delay_length !== 10'd217) begin n_bad++; $display("FAIL on_dl got %0d want 217", delay_length); end
    n_cmp++; if (velocity !== 7'd100) begin n_bad++; $display("FAIL on_vel got %0d want 100", velocity); end
    n_cmp++; if (note !== 7'd69) begin n_bad++; $display("FAIL on_note got %0d want 69", note); end
    n_cmp++; if (note_active !== 1'b1) begin n_bad++; $display("FAIL on_active got %b want 1", note_active); end
    idle(10);
  endtask

  task automatic test_running_status;
    int f, l, base;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    wait_trig(f, l);
    n_cmp++; if (f !== 4) begin n_bad++; $display("FAIL rs_first_low got %0d want 4", f); end
    n_cmp++; if (delay_length !== 10'd366) begin n_bad++; $display("FAIL rs_dl got %0d want 366", delay_length); end
    n_cmp++; if (note_active !== 1'b1) begin n_bad++; $display("FAIL rs_active_on got %b want 1", note_active); end
    idle(10);
    base = s_note.size();
    send_byte(8'h3C); send_byte(8'h00);
    idle(30);
    n_cmp++; if (note_active !== 1'b0) begin n_bad++; $display("FAIL rs_active_off got %b want 0", note_active); end
    n_cmp++; if (s_note.size() !== base) begin n_bad++; $display("FAIL rs_no_retrig got %0d strikes want %0d", s_note.size(), base); end
  endtask

  task automatic test_realtime;
    int f, l;
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h7F); send_byte(8'hFE); send_byte(8'h7F);
    wait_trig(f, l);
    n_cmp++; if (f !== 9) begin n_bad++; $display("FAIL rt_first_low got %0d want 9", f); end
    n_cmp++; if (note !== 7'd127) begin n_bad++; $display("FAIL rt_note got %0d want 127", note); end
    n_cmp++; if (delay_length !== 10'd6) begin n_bad++; $display("FAIL rt_dl got %0d want 6", delay_length); end
    n_cmp++; if (velocity !== 7'd127) begin n_bad++; $display("FAIL rt_vel got %0d want 127", velocity); end
    n_cmp++; if (l !== 8) begin n_bad++; $display("FAIL rt_low_len got %0d want 8", l); end
    idle(10);
  endtask

  task automatic test_fold_channel;
    int f, l, base;
    send_byte(8'h90); send_byte(8'h14); send_byte(8'h10);
    wait_trig(f, l);
    n_cmp++; if (f !== 6) begin n_bad++; $display("FAIL fold_first_low got %0d want 6", f); end
    n_cmp++; if (delay_length !== 10'd461) begin n_bad++; $display("FAIL fold_dl got %0d want 461", delay_length); end
    idle(10);
    base = s_note.size();
    send_byte(8'h91); send_byte(8'h40); send_byte(8'h40);
    idle(30);
`ifdef KP_MIDI_OMNI_EN
    n_cmp++; if (s_note.size() !== base + 1) begin n_bad++; $display("FAIL omni_strike got %0d strikes want %0d", s_note.size(), base + 1); end
    n_cmp++; if (delay_length !== 10'd290) begin n_bad++; $display("FAIL omni_dl got %0d want 290", delay_length); end
`else
    // running status was cleared by the foreign channel, so bare data is dropped too
    send_byte(8'h45); send_byte(8'h64);
    idle(30);
    n_cmp++; if (s_note.size() !== base) begin n_bad++; $display("FAIL ch_filter got %0d strikes want %0d", s_note.size(), base); end
`endif
    base = s_note.size();
    send_byte(8'h90); send_byte(8'hF0); send_byte(8'h30); send_byte(8'h20);
    idle(30);
    n_cmp++; if (s_note.size() !== base) begin n_bad++; $display("FAIL sys_clear got %0d strikes want %0d", s_note.size(), base); end
  endtask

  task automatic test_back_to_back;
    int base, d0;
    base = s_note.size();
    d0 = drops;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    idle(3);
    n_cmp++; if (trig !== 1'b0) begin n_bad++; $display("FAIL b2b_hold got %b want 0", trig); end
    send_byte(8'h3E); send_byte(8'h40); send_byte(8'h40); send_byte(8'h40);
    idle(60);
    n_cmp++; if (drops - d0 !== 1) begin n_bad++; $display("FAIL b2b_drops got %0d want 1", drops - d0); end
    n_cmp++; if (s_note.size() !== base + 2) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", s_note.size(), base + 2); end
    if (s_note.size() >= base + 2) begin
      n_cmp++; if (s_note[base] !== 7'd60) begin n_bad++; $display("FAIL b2b_note0 got %0d want 60", s_note[base]); end
      n_cmp++; if (s_dl[base] !== 10'd366) begin n_bad++; $display("FAIL b2b_dl0 got %0d want 366", s_dl[base]); end
      n_cmp++; if (s_note[base+1] !== 7'd64) begin n_bad++; $display("FAIL b2b_note1 got %0d want 64", s_note[base+1]); end
      n_cmp++; if (s_dl[base+1] !== 10'd290) begin n_bad++; $display("FAIL b2b_dl1 got %0d want 290", s_dl[base+1]); end
    end
  endtask

  task automatic test_reset_mid_hold;
    int f, l;
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    idle(5);
    n_cmp++; if (trig !== 1'b0) begin n_bad++; $display("FAIL mid_in_hold got %b want 0", trig); end
    reset_n = 1'b0;
    @(negedge a_clk);
    reset_n = 1'b1;
    n_cmp++; if (trig !== 1'b1) begin n_bad++; $display("FAIL mid_trig got %b want 1", trig); end
    n_cmp++; if (velocity !== 7'd0) begin n_bad++; $display("FAIL mid_vel got %0d want 0", velocity); end
    n_cmp++; if (delay_length !== 10'd0) begin n_bad++; $display("FAIL mid_dl got %0d want 0", delay_length); end
    n_cmp++; if (note !== 7'd0) begin n_bad++; $display("FAIL mid_note got %0d want 0", note); end
    n_cmp++; if (note_active !== 1'b0) begin n_bad++; $display("FAIL mid_active got %b want 0", note_active); end
    send_byte(8'h90); send_byte(8'h30); send_byte(8'h20);
    wait_trig(f, l);
    n_cmp++; if (f !== 3) begin n_bad++; $display("FAIL mid_first_low got %0d want 3", f); end
    n_cmp++; if (delay_length !== 10'd733) begin n_bad++; $display("FAIL mid_dl_after got %0d want 733", delay_length); end
    n_cmp++; if (velocity !== 7'd32) begin n_bad++; $display("FAIL mid_vel_after got %0d want 32", velocity); end
    idle(10);
  endtask

  initial begin
    @(negedge a_clk);
    test_reset;
    test_note_on;
    test_running_status;
    test_realtime;
    test_fold_channel;
    test_back_to_back;
    test_reset_mid_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
